pool_buf_reader: RTL and testbench

//  Consumer side of the max-pool output buffers. maxPool writes three pooled rows (bram_num 0..2,

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/pool_skid_fifo.sv | 58 +++++
 rtl/pool_buf_reader.sv | 177 +++++++++++++++++
 tb/tb_pool_buf_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the pooled-row buffer reader.
package cnn_pkg;

  localparam int BD       = 18;
  localparam int OUTWIDTH = 960;
  localparam int NBUF     = 3;
  localparam int AW       = $clog2(OUTWIDTH);
  localparam int BW       = $clog2(NBUF);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One buffered output word: three channels plus row/frame end markers.
  typedef struct packed {
    logic [BD-1:0] c0;
    logic [BD-1:0] c1;
    logic [BD-1:0] c2;
    logic          eol;
    logic          last;
  } pix_t;

endpackage

// File: rtl/pool_skid_fifo.sv
// Two-entry FIFO that soaks up the one-cycle BRAM read latency.
module pool_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] headData,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] entry0_q;
  logic [W-1:0] entry1_q;
  logic         wrPtr_q;
  logic         rdPtr_q;
  logic [1:0]   count_q;
  logic         doPush;
  logic         doPop;

  assign doPop  = pop && (count_q != 2'd0);
  assign doPush = push && ((count_q != 2'd2) || doPop);

  // Write the incoming word into the slot under the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wrPtr_q  <= 1'b0;
    end else if (doPush) begin
      if (wrPtr_q) entry1_q <= pushData;
      else         entry0_q <= pushData;
      wrPtr_q <= ~wrPtr_q;
    end
  end

  // Advance the read pointer on pop and keep the occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (doPop) rdPtr_q <= ~rdPtr_q;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign headData = rdPtr_q ? entry1_q : entry0_q;
  assign count    = count_q;
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/pool_buf_reader.sv
// Reads the three pooled row buffers after maxPool signals completion and
// streams the pixels downstream on a valid/ready interface.
module pool_buf_reader
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start_in,
  output logic          rden,
  output logic [AW-1:0] rdaddr,
  output logic [BW-1:0] bram_num,
  input  logic [BD-1:0] q_c0,
  input  logic [BD-1:0] q_c1,
  input  logic [BD-1:0] q_c2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BD-1:0] out_c0,
  output logic [BD-1:0] out_c1,
  output logic [BD-1:0] out_c2,
  output logic          out_eol,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  logic          s0_q;
  logic          s1_q;
  logic          startPulse;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [AW-1:0] nxtAddr_q;
  logic [AW-1:0] nxtAddr_d;
  logic [BW-1:0] nxtBuf_q;
  logic [BW-1:0] nxtBuf_d;
  logic [AW-1:0] lastAddr_q;
  logic [BW-1:0] lastBuf_q;
  logic          inflight_q;
  logic          pendEol_q;
  logic          pendLast_q;
  logic          done_q;
  logic          overrun_q;
  logic          issue;
  logic          isLastAddr;
  logic          isLastBuf;
  logic          pop;
  logic          finalBeat;
  logic [1:0]    fifoCnt;
  logic          fifoEmpty;
  pix_t          pushWord;
  pix_t          head;

  assign startPulse = s0_q & ~s1_q;
  assign isLastAddr = (nxtAddr_q == AW'(OUTWIDTH - 1));
  assign isLastBuf  = (nxtBuf_q == BW'(NBUF - 1));
  assign pop        = ~fifoEmpty & out_ready;
  assign finalBeat  = pop & head.last;

  // A word leaving the FIFO this cycle frees its slot, which keeps the
  // stream at one word per cycle while never exceeding two buffered words.
  assign issue = (state_q == ST_FETCH) &&
                 (({1'b0, fifoCnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // Two-flop sample of the maxPool completion pulse for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= start_in;
      s1_q <= s0_q;
    end
  end

  // Frame sequencing and next-read address generation.
  always_comb begin
    state_d   = state_q;
    nxtAddr_d = nxtAddr_q;
    nxtBuf_d  = nxtBuf_q;
    case (state_q)
      ST_IDLE: begin
        if (startPulse) begin
          state_d   = ST_FETCH;
          nxtAddr_d = '0;
          nxtBuf_d  = '0;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          if (isLastAddr) begin
            nxtAddr_d = '0;
            if (isLastBuf) state_d  = ST_DRAIN;
            else           nxtBuf_d = nxtBuf_q + 1'b1;
          end else begin
            nxtAddr_d = nxtAddr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (finalBeat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address counters and the tag of the read currently in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      nxtAddr_q  <= '0;
      nxtBuf_q   <= '0;
      lastAddr_q <= '0;
      lastBuf_q  <= '0;
      inflight_q <= 1'b0;
      pendEol_q  <= 1'b0;
      pendLast_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxtAddr_q  <= nxtAddr_d;
      nxtBuf_q   <= nxtBuf_d;
      inflight_q <= issue;
      pendEol_q  <= issue && isLastAddr;
      pendLast_q <= issue && isLastAddr && isLastBuf;
      if (issue) begin
        lastAddr_q <= nxtAddr_q;
        lastBuf_q  <= nxtBuf_q;
      end
    end
  end

  // Completion pulse and sticky flag for a start that arrives mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DRAIN) && finalBeat;
      if (startPulse && (state_q != ST_IDLE)) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    pushWord      = '0;
    pushWord.c0   = q_c0;
    pushWord.c1   = q_c1;
    pushWord.c2   = q_c2;
    pushWord.eol  = pendEol_q;
    pushWord.last = pendLast_q;
  end

  pool_skid_fifo #(
    .W($bits(pix_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .pushData (pushWord),
    .pop      (pop),
    .headData (head),
    .count    (fifoCnt),
    .empty    (fifoEmpty)
  );

  assign rden      = issue;
  assign rdaddr    = issue ? nxtAddr_q : lastAddr_q;
  assign bram_num  = issue ? nxtBuf_q : lastBuf_q;
  assign out_valid = ~fifoEmpty;
  assign out_c0    = head.c0;
  assign out_c1    = head.c1;
  assign out_c2    = head.c2;
  assign out_eol   = head.eol;
  assign out_last  = head.last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pool_buf_reader.sv
// Directed bench for pool_buf_reader with a behavioural BRAM model.
module tb_pool_buf_reader;

  localparam int TBD    = 18;
  localparam int TWIDTH = 960;
  localparam int TBEATS = 2880;

  logic            clk;
  logic            reset;
  logic            start_in;
  logic            rden;
  logic [9:0]      rdaddr;
  logic [1:0]      bram_num;
  logic [TBD-1:0]  q_c0;
  logic [TBD-1:0]  q_c1;
  logic [TBD-1:0]  q_c2;
  logic            out_valid;
  logic            out_ready;
  logic [TBD-1:0]  out_c0;
  logic [TBD-1:0]  out_c1;
  logic [TBD-1:0]  out_c2;
  logic            out_eol;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overrun;

  int          checks;
  int          failures;
  int          readyMode;
  logic        startNext;
  logic        monEn;
  int          beatIdx;
  int          rdCount;
  logic        doneExpect;
  logic        frameDone;
  logic        prevStall;
  logic [55:0] prevData;

  pool_buf_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .rden      (rden),
    .rdaddr    (rdaddr),
    .bram_num  (bram_num),
    .q_c0      (q_c0),
    .q_c1      (q_c1),
    .q_c2      (q_c2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c0    (out_c0),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [TBD-1:0] pixBase(int bufSel, int addr);
    return TBD'(addr + 1024 * bufSel);
  endfunction

  function automatic logic [55:0] expWord(int idx);
    logic [TBD-1:0] c0;
    int             bufSel;
    int             addr;
    bufSel = idx / TWIDTH;
    addr   = idx % TWIDTH;
    c0     = pixBase(bufSel, addr);
    return {c0, c0 + 18'h10000, c0 + 18'h20000, addr == TWIDTH - 1, idx == TBEATS - 1};
  endfunction

  // BRAM model: data appears one cycle after rden, junk otherwise.
  always @(posedge clk) begin
    if (rden) begin
      q_c0 <= pixBase(int'(bram_num), int'(rdaddr));
      q_c1 <= pixBase(int'(bram_num), int'(rdaddr)) + 18'h10000;
      q_c2 <= pixBase(int'(bram_num), int'(rdaddr)) + 18'h20000;
    end else begin
      q_c0 <= 18'h3FFFF;
      q_c1 <= 18'h3FFFF;
      q_c2 <= 18'h3FFFF;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic monReset();
    beatIdx    = 0;
    rdCount    = 0;
    doneExpect = 1'b0;
    frameDone  = 1'b0;
    prevStall  = 1'b0;
    prevData   = '0;
  endtask

  task automatic monitorStep();
    logic [55:0] cur;
    cur = {out_c0, out_c1, out_c2, out_eol, out_last};
    if (rden) rdCount++;
    if (doneExpect) begin
      checkOutput("done_pulse", 64'(done), 64'd1);
      checkOutput("busy_drop", 64'(busy), 64'd0);
      doneExpect = 1'b0;
      frameDone  = 1'b1;
    end else if (done) begin
      checkOutput("done_spurious", 64'(done), 64'd0);
    end
    if (prevStall) begin
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_data", 64'(cur), 64'(prevData));
    end
    if (out_valid && out_ready) begin
      if (beatIdx < TBEATS)
        checkOutput($sformatf("beat%0d", beatIdx), 64'(cur), 64'(expWord(beatIdx)));
      else
        checkOutput("extra_beat", 64'(beatIdx), 64'(TBEATS - 1));
      if (beatIdx == TBEATS - 1) doneExpect = 1'b1;
      beatIdx++;
    end
    prevStall = out_valid && !out_ready;
    prevData  = cur;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    start_in = startNext;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    @(negedge clk);
    if (monEn) monitorStep();
  endtask

  task automatic startFrame(input int len);
    startNext = 1'b1;
    repeat (len) applyStimulus();
    startNext = 1'b0;
  endtask

  task automatic waitFrame(input string tag, input int bound);
    int n;
    n = 0;
    while (!frameDone && n < bound) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_frame_done"}, 64'(frameDone), 64'd1);
    checkOutput({tag, "_beats"}, 64'(beatIdx), 64'(TBEATS));
    checkOutput({tag, "_reads"}, 64'(rdCount), 64'(TBEATS));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_rden"}, 64'(rden), 64'd0);
    checkOutput({tag, "_rdaddr"}, 64'(rdaddr), 64'd0);
    checkOutput({tag, "_bram_num"}, 64'(bram_num), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_word"}, 64'({out_c0, out_c1, out_c2, out_eol, out_last}), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    start_in  = 1'b0;
    out_ready = 1'b0;
    readyMode = 0;
    startNext = 1'b0;
    monEn     = 1'b0;
    monReset();

    #3;
    checkIdle("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    // Test 1: full frame with out_ready high, checking start latency.
    $display("[TB] test 1: full-rate frame");
    monReset();
    monEn = 1'b1;
    startNext = 1'b1;
    applyStimulus();
    startNext = 1'b0;
    applyStimulus();
    checkOutput("t1_busy_sync", 64'(busy), 64'd0);
    applyStimulus();
    checkOutput("t1_busy_rise", 64'(busy), 64'd1);
    checkOutput("t1_first_rden", 64'(rden), 64'd1);
    checkOutput("t1_first_addr", 64'({bram_num, rdaddr}), 64'd0);
    applyStimulus();
    checkOutput("t1_valid_early", 64'(out_valid), 64'd0);
    checkOutput("t1_second_addr", 64'({bram_num, rdaddr}), 64'd1);
    applyStimulus();
    checkOutput("t1_first_valid", 64'(out_valid), 64'd1);
    waitFrame("t1", 4000);
    checkOutput("t1_overrun", 64'(overrun), 64'd0);

    // Test 2: random backpressure.
    $display("[TB] test 2: random out_ready");
    readyMode = 1;
    monReset();
    startFrame(1);
    waitFrame("t2", 8000);

    // Test 3: downstream stalled right after start.
    $display("[TB] test 3: stalled output");
    readyMode = 2;
    monReset();
    startFrame(1);
    repeat (100) applyStimulus();
    checkOutput("t3_reads", 64'(rdCount), 64'd2);
    checkOutput("t3_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_rden", 64'(rden), 64'd0);
    readyMode = 0;
    waitFrame("t3", 4000);

    // Test 4: second start mid-frame.
    $display("[TB] test 4: start while busy");
    monReset();
    startFrame(1);
    n = 0;
    while (beatIdx < 500 && n < 4000) begin
      applyStimulus();
      n++;
    end
    checkOutput("t4_reach500", 64'(beatIdx >= 500), 64'd1);
    startFrame(1);
    waitFrame("t4", 4000);
    checkOutput("t4_overrun", 64'(overrun), 64'd1);

    // Test 5: reset mid-frame, then a clean frame.
    $display("[TB] test 5: reset mid-frame");
    monReset();
    startFrame(1);
    n = 0;
    while (beatIdx < 1200 && n < 4000) begin
      applyStimulus();
      n++;
    end
    checkOutput("t5_reach1200", 64'(beatIdx >= 1200), 64'd1);
    monEn = 1'b0;
    #1 reset = 1'b0;
    #1 checkIdle("t5_midrst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkIdle("t5_postrst");
    monReset();
    monEn = 1'b1;
    startFrame(1);
    waitFrame("t5", 4000);
    checkOutput("t5_overrun", 64'(overrun), 64'd0);

    // Test 6: long start level gives a single frame.
    $display("[TB] test 6: held start_in");
    monReset();
    startFrame(10);
    waitFrame("t6", 4000);
    repeat (20) applyStimulus();
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_reads", 64'(rdCount), 64'(TBEATS));
    checkOutput("t6_overrun", 64'(overrun), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
